ldm_stm_sequencer: RTL and testbench
====================================

# ldm_stm_sequencer

Sequencer for ARMv4 block data transfer (LDM/STM). It decodes the register list and addressing mode of the latched instruction, and walks the list one register per memory beat. Each beat presents the register number and word address to the register bank and memory interface. It also produces the base-register writeback value. It sits upstream of the register-bank encapsulation and replaces that block's free-running Rm/Rd counters with list-aware register selection.

## Interface
Parameters:
- `ADDR_W`, 32, width of base, address and writeback values.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `START`  in  1  one-cycle request; accepted only in IDLE.
- `IR`  in  32  instruction; sampled on an accepted `START`. Fields used: P=[24], U=[23], W=[21], L=[20], Rn=[19:16], list=[15:0].
- `BASE`  in  ADDR_W  Rn value (A_BUS); sampled on an accepted `START`.
- `MEM_READY`  in  1  memory accepts or returns the current beat.
- `ABORT`  in  1  data abort for the current beat.
- `ACCESS_VALID`  out  1  beat presented; `REG_NUM`, `ADDR` and `IS_LOAD` are stable while this is high.
- `REG_NUM`  out  4  register for the current beat.
- `ADDR`  out  ADDR_W  word address for the current beat; bits [1:0] are always 0.
- `IS_LOAD`  out  1  latched L bit.
- `WB_EN`  out  1  one-cycle base writeback strobe.
- `WB_REG`  out  4  latched Rn.
- `WB_VALUE`  out  ADDR_W  new base value.
- `PC_LOADED`  out  1  R15 was loaded by an LDM; valid with `DONE`.
- `ABORTED`  out  1  sequence terminated by `ABORT`; valid with `DONE`.
- `BUSY`  out  1  high whenever the state is not IDLE.
- `DONE`  out  1  one-cycle completion pulse.

## Operation
States: IDLE, XFER, WB, FIN.
- **Accepting a request.** `START` in IDLE latches `IR`, `BASE`, the list into `mask`, and n = popcount(list).
  - For a non-empty list the sequencer goes to XFER.
  - For an empty list see Configuration.
  - `START` outside IDLE is ignored.
- **Start address** (arithmetic modulo 2^ADDR_W):
  - IA: BASE
  - IB: BASE+4
  - DA: BASE−4n+4
  - DB: BASE−4n
- **Writeback value:** U ? BASE+4n : BASE−4n.
- **XFER.**
  - `REG_NUM` is the lowest set bit of `mask`.
  - A beat completes on a cycle where `ACCESS_VALID & MEM_READY & ~ABORT`. On completion the sequencer clears that bit and adds 4 to `ADDR`. Addresses always ascend, whatever U is.
  - If an LDM completes a beat with `REG_NUM`=15, `PC_LOADED` is set.
  - When `mask` becomes zero, the next state is WB if W=1, otherwise FIN.
- **Abort.** `ACCESS_VALID & ABORT` ends the sequence:
  - `ABORTED` is set, the sequencer goes to FIN, and writeback is suppressed.
  - `ABORT` takes priority over `MEM_READY` in the same cycle.
- **WB.** `WB_EN` is high for one cycle. Writeback is suppressed (WB is skipped) when L=1 and list[Rn]=1, because the loaded value wins.
- **FIN.** `DONE` is high for one cycle, then the sequencer returns to IDLE. `PC_LOADED` and `ABORTED` are cleared on the next accepted `START`.

## Timing
- **Reset values.** Reset assertion forces IDLE immediately, even in the middle of a sequence. All outputs reset to 0: `ACCESS_VALID`, `WB_EN`, `DONE`, `BUSY`, `PC_LOADED`, `ABORTED`, `REG_NUM`, `ADDR`, `WB_REG`, `WB_VALUE`, `IS_LOAD`.
- **First beat.** `START` at cycle 0; `ACCESS_VALID` is high from cycle 1.
- **Beat rate.** With `MEM_READY` held high there is one beat per cycle, so a sequence lasts n cycles in XFER, plus 1 cycle in WB if writing back, plus 1 cycle in FIN.
- **Waiting on memory.** While `MEM_READY`=0, `ACCESS_VALID`, `REG_NUM` and `ADDR` hold unchanged.
- **Earliest restart.** `BUSY` is high from cycle 1 through the `DONE` cycle. The earliest next `START` is accepted the cycle after `DONE`.

## Configuration
Macro: `LDM_STM_EMPTY_LIST_R15_EN`.
- **Defined:** an empty list behaves as if the list were {R15} for the transfer. The base still adjusts by 0x40 (n treated as 16) for both start address and writeback.
- **Undefined:** an empty list goes from IDLE directly to FIN. There are no beats, no writeback, and `DONE` arrives at cycle 1.

## Test plan
- LDMIA, IR list 0x00F0, BASE=0x1000, W=1, `MEM_READY` held high → beats R4@0x1000, R5@0x1004, R6@0x1008, R7@0x100C; `WB_VALUE`=0x1010; `DONE` at cycle 6.
- STMDB with W=1, list 0x4003 (R0, R1, R14), BASE=0x2000 → beats R0@0x1FF4, R1@0x1FF8, R14@0x1FFC; `WB_VALUE`=0x1FF4.
- LDMIB, Rn=R2, list 0x8004, W=1, `MEM_READY` low for 2 cycles on the first beat → beat R2@BASE+4 is held for 3 cycles; no `WB_EN`; `PC_LOADED`=1 at `DONE`.
- LDMDA, list 0x0007, `ABORT` on the 2nd beat at the same time as `MEM_READY` → only R0 completes; `ABORTED`=1; no `WB_EN`; `DONE` one cycle later.
- Empty list, BASE=0x3000, IA, W=1:
  - with the macro defined → single beat R15@0x3000 and `WB_VALUE`=0x3040;
  - without it → `DONE` at cycle 1 with no beats.
- `rst` asserted during the 2nd beat of a 4-register LDM → all outputs are 0 immediately; a `START` after reset release runs a full, correct sequence.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// ldm_stm_sequencer
//
// Block data transfer (LDM/STM) sequencer. A request latches the instruction
// and base value. The register list is then walked from the lowest register
// upward, one register per memory beat. Beat addresses always ascend. The
// start address is chosen so that the same ascending walk covers the IA, IB,
// DA and DB addressing modes. The new base value is produced as a one-cycle
// writeback strobe.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   START        one-cycle request, honoured only when idle
//   IR[31:0]     instruction (P=24, U=23, W=21, L=20, Rn=19:16, list=15:0)
//   BASE         Rn value, sampled with an accepted START
//   MEM_READY    memory accepts/returns the current beat
//   ABORT        data abort on the current beat
//   ACCESS_VALID beat presented (REG_NUM/ADDR/IS_LOAD stable while high)
//   REG_NUM      register for the current beat
//   ADDR         word-aligned address for the current beat
//   IS_LOAD      latched L bit
//   WB_EN        one-cycle base writeback strobe
//   WB_REG       latched Rn
//   WB_VALUE     new base value
//   PC_LOADED    R15 was loaded by an LDM (valid with DONE)
//   ABORTED      sequence ended by ABORT (valid with DONE)
//   BUSY         sequencer not idle
//   DONE         one-cycle completion pulse
//
// Build option: LDM_STM_EMPTY_LIST_R15_EN
//   defined   - an empty list transfers R15, and the base moves by 0x40
//   undefined - an empty list completes at once, with no beats and no writeback
// ---------------------------------------------------------------------------
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic [31:0]       IR,
  input  logic [ADDR_W-1:0] BASE,
  input  logic              MEM_READY,
  input  logic              ABORT,
  output logic              ACCESS_VALID,
  output logic [3:0]        REG_NUM,
  output logic [ADDR_W-1:0] ADDR,
  output logic              IS_LOAD,
  output logic              WB_EN,
  output logic [3:0]        WB_REG,
  output logic [ADDR_W-1:0] WB_VALUE,
  output logic              PC_LOADED,
  output logic              ABORTED,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  // Number of set bits in a 16-bit register list.
  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, m[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit. Returns 0 for an empty mask.
  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) begin
        idx = i[3:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        mask_q, mask_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         reg_num_q, reg_num_d;
  logic               is_load_q, is_load_d;
  logic [3:0]         wb_reg_q, wb_reg_d;
  logic [ADDR_W-1:0]  wb_value_q, wb_value_d;
  logic               wb_do_q, wb_do_d;
  logic               pc_loaded_q, pc_loaded_d;
  logic               aborted_q, aborted_d;
  logic               access_valid_q, access_valid_d;
  logic               wb_en_q, wb_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Request decode: the effective list, the transfer count and the addresses.
  logic [15:0]        list_s;
  logic               list_empty_s;
  logic [15:0]        list_eff_s;
  logic [4:0]         n_eff_s;
  logic [ADDR_W-1:0]  four_n_s;
  logic [ADDR_W-1:0]  start_addr_s;
  logic [ADDR_W-1:0]  new_base_s;
  logic               wb_allowed_s;
  logic [15:0]        beat_bit_s;
  logic [15:0]        mask_next_s;
  logic               unused_ir_s;

  assign unused_ir_s = ^{IR[31:25], IR[22]};

  // Decode the register list and addressing mode of the presented instruction.
  always_comb begin
    list_s       = IR[15:0];
    list_empty_s = (list_s == 16'h0000);
`ifdef LDM_STM_EMPTY_LIST_R15_EN
    // An empty list transfers R15, but the base moves as if all 16 registers were listed.
    if (list_empty_s) begin
      list_eff_s = 16'h8000;
      n_eff_s    = 5'd16;
    end else begin
      list_eff_s = list_s;
      n_eff_s    = popcount16(list_s);
    end
`else
    list_eff_s = list_s;
    n_eff_s    = popcount16(list_s);
`endif
    four_n_s = {{(ADDR_W-7){1'b0}}, n_eff_s, 2'b00};
    // The lowest address is chosen so that all four modes walk upward.
    case ({IR[24], IR[23]})
      2'b01:   start_addr_s = BASE;                          // IA
      2'b11:   start_addr_s = BASE + WORD_STEP;              // IB
      2'b00:   start_addr_s = BASE - four_n_s + WORD_STEP;   // DA
      2'b10:   start_addr_s = BASE - four_n_s;               // DB
      default: start_addr_s = BASE;
    endcase
    if (IR[23]) begin
      new_base_s = BASE + four_n_s;
    end else begin
      new_base_s = BASE - four_n_s;
    end
    // When an LDM lists its own base register, the loaded value replaces the writeback.
    wb_allowed_s = IR[21] & ~(IR[20] & list_s[IR[19:16]]);
  end

  // Next-state, datapath and output decode of the sequencer.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    reg_num_d   = reg_num_q;
    is_load_d   = is_load_q;
    wb_reg_d    = wb_reg_q;
    wb_value_d  = wb_value_q;
    wb_do_d     = wb_do_q;
    pc_loaded_d = pc_loaded_q;
    aborted_d   = aborted_q;
    beat_bit_s  = 16'h0001 << reg_num_q;
    mask_next_s = mask_q & ~beat_bit_s;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          is_load_d   = IR[20];
          wb_reg_d    = IR[19:16];
          wb_value_d  = new_base_s;
          wb_do_d     = wb_allowed_s;
          pc_loaded_d = 1'b0;
          aborted_d   = 1'b0;
          mask_d      = list_eff_s;
          reg_num_d   = lowest_set(list_eff_s);
          addr_d      = {start_addr_s[ADDR_W-1:2], 2'b00};
          if (list_eff_s == 16'h0000) begin
            state_d = S_FIN;
          end else begin
            state_d = S_XFER;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_XFER: begin
        // An abort wins over a ready memory in the same cycle.
        if (ABORT) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else if (MEM_READY) begin
          if (is_load_q && (reg_num_q == 4'd15)) begin
            pc_loaded_d = 1'b1;
          end else begin
            pc_loaded_d = pc_loaded_q;
          end
          mask_d = mask_next_s;
          addr_d = addr_q + WORD_STEP;
          if (mask_next_s == 16'h0000) begin
            // The last register number stays on REG_NUM after the final beat.
            reg_num_d = reg_num_q;
            if (wb_do_q) begin
              state_d = S_WB;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            reg_num_d = lowest_set(mask_next_s);
            state_d   = S_XFER;
          end
        end else begin
          state_d = S_XFER;
        end
      end

      S_WB: begin
        state_d = S_FIN;
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they leave the block from flops.
    access_valid_d = (state_d == S_XFER);
    wb_en_d        = (state_d == S_WB);
    done_d         = (state_d == S_FIN);
    busy_d         = (state_d != S_IDLE);
  end

  // State and output registers. Reset clears every output at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      mask_q         <= 16'h0000;
      addr_q         <= {ADDR_W{1'b0}};
      reg_num_q      <= 4'd0;
      is_load_q      <= 1'b0;
      wb_reg_q       <= 4'd0;
      wb_value_q     <= {ADDR_W{1'b0}};
      wb_do_q        <= 1'b0;
      pc_loaded_q    <= 1'b0;
      aborted_q      <= 1'b0;
      access_valid_q <= 1'b0;
      wb_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      addr_q         <= addr_d;
      reg_num_q      <= reg_num_d;
      is_load_q      <= is_load_d;
      wb_reg_q       <= wb_reg_d;
      wb_value_q     <= wb_value_d;
      wb_do_q        <= wb_do_d;
      pc_loaded_q    <= pc_loaded_d;
      aborted_q      <= aborted_d;
      access_valid_q <= access_valid_d;
      wb_en_q        <= wb_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign ACCESS_VALID = access_valid_q;
  assign REG_NUM      = reg_num_q;
  assign ADDR         = addr_q;
  assign IS_LOAD      = is_load_q;
  assign WB_EN        = wb_en_q;
  assign WB_REG       = wb_reg_q;
  assign WB_VALUE     = wb_value_q;
  assign PC_LOADED    = pc_loaded_q;
  assign ABORTED      = aborted_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ldm_stm_sequencer
//
// Table of LDM/STM requests with hand-computed start address, writeback and
// completion cycle. Expected beats are pushed to a scoreboard when a request
// is driven, and popped as the sequencer presents them. A hand-written
// sequence covers reset in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_ldm_stm_sequencer;

  logic        clk;
  logic        rst;
  logic        START;
  logic [31:0] IR;
  logic [31:0] BASE;
  logic        MEM_READY;
  logic        ABORT;
  logic        ACCESS_VALID;
  logic [3:0]  REG_NUM;
  logic [31:0] ADDR;
  logic        IS_LOAD;
  logic        WB_EN;
  logic [3:0]  WB_REG;
  logic [31:0] WB_VALUE;
  logic        PC_LOADED;
  logic        ABORTED;
  logic        BUSY;
  logic        DONE;

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .START(START), .IR(IR), .BASE(BASE),
    .MEM_READY(MEM_READY), .ABORT(ABORT), .ACCESS_VALID(ACCESS_VALID),
    .REG_NUM(REG_NUM), .ADDR(ADDR), .IS_LOAD(IS_LOAD), .WB_EN(WB_EN),
    .WB_REG(WB_REG), .WB_VALUE(WB_VALUE), .PC_LOADED(PC_LOADED),
    .ABORTED(ABORTED), .BUSY(BUSY), .DONE(DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] ir;
    logic [31:0] base;
    int          stall;      // cycles MEM_READY stays low on the first beat
    int          abort_beat; // beat index that sees ABORT, -1 for none
    bit          poke;       // extra START while busy (must be ignored)
    logic [31:0] exp_start;
    bit          exp_wb;
    logic [31:0] exp_wbv;
    bit          exp_pc;
    bit          exp_ab;
    int          exp_done;
  } vec_t;

  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] a;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    checks;
  int    errors;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input int id, input logic [31:0] ir, input logic [31:0] base,
                         input int stall, input int abort_beat, input bit poke,
                         input logic [31:0] exp_start, input bit exp_wb,
                         input logic [31:0] exp_wbv, input bit exp_pc,
                         input bit exp_ab, input int exp_done);
    vec_t v;
    v.id = id; v.ir = ir; v.base = base; v.stall = stall;
    v.abort_beat = abort_beat; v.poke = poke; v.exp_start = exp_start;
    v.exp_wb = exp_wb; v.exp_wbv = exp_wbv; v.exp_pc = exp_pc;
    v.exp_ab = exp_ab; v.exp_done = exp_done;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int    k;
    int    cyc;
    int    stall_left;
    int    beat;
    int    wb_seen;
    int    valid_cycles;
    int    exp_valid;
    bit    done_seen;
    beat_t e;
    string tag;

    tag = $sformatf("v%0d", v.id);
    // Scoreboard: the listed registers in ascending order at ascending addresses.
    k = 0;
    sb.delete();
    for (int r = 0; r < 16; r++) begin
      if (v.ir[r]) begin
        if (v.abort_beat < 0 || k < v.abort_beat) begin
          e.r = r[3:0];
          e.a = v.exp_start + 32'(4 * k);
          sb.push_back(e);
        end
        k++;
      end
    end
`ifdef LDM_STM_EMPTY_LIST_R15_EN
    if (v.ir[15:0] == 16'h0000) begin
      e.r = 4'd15;
      e.a = v.exp_start;
      sb.push_back(e);
    end
`endif
    exp_valid = sb.size() + v.stall + ((v.abort_beat >= 0) ? 1 : 0);

    @(posedge clk); #1;
    START = 1'b1; IR = v.ir; BASE = v.base; MEM_READY = 1'b1; ABORT = 1'b0;
    @(posedge clk); #1;
    START = 1'b0; IR = 32'h0; BASE = 32'h0;
    cyc = 1; stall_left = v.stall; beat = 0; wb_seen = 0;
    valid_cycles = 0; done_seen = 1'b0;

    while (!done_seen && cyc < 60) begin
      MEM_READY = (stall_left == 0);
      ABORT     = (beat == v.abort_beat);
      if (v.poke && cyc == 2) begin
        START = 1'b1; IR = 32'hE8BF_FFFF; BASE = 32'hDEAD_0000;
      end else begin
        START = 1'b0; IR = 32'h0; BASE = 32'h0;
      end
      @(negedge clk);
      chk({tag, " busy"}, 128'(BUSY), 128'(1'b1));
      if (ACCESS_VALID) begin
        valid_cycles++;
        chk({tag, " is_load"}, 128'(IS_LOAD), 128'(v.ir[20]));
        if (ABORT) begin
          // The aborted beat is not a completed transfer.
        end else if (sb.size() == 0) begin
          chk({tag, " unexpected beat reg"}, 128'(REG_NUM), 128'(5'h1F));
        end else begin
          chk({tag, " reg_num"}, 128'(REG_NUM), 128'(sb[0].r));
          chk({tag, " addr"}, 128'(ADDR), 128'(sb[0].a));
          if (MEM_READY) begin
            void'(sb.pop_front());
            beat++;
          end else begin
            stall_left--;
          end
        end
      end
      if (WB_EN) begin
        wb_seen++;
        chk({tag, " wb_value"}, 128'(WB_VALUE), 128'(v.exp_wbv));
        chk({tag, " wb_reg"}, 128'(WB_REG), 128'(v.ir[19:16]));
      end
      if (DONE) begin
        done_seen = 1'b1;
        chk({tag, " done_cycle"}, 128'(cyc), 128'(v.exp_done));
        chk({tag, " pc_loaded"}, 128'(PC_LOADED), 128'(v.exp_pc));
        chk({tag, " aborted"}, 128'(ABORTED), 128'(v.exp_ab));
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, " done_seen"}, 128'(done_seen), 128'(1'b1));
    chk({tag, " wb_count"}, 128'(wb_seen), 128'(v.exp_wb ? 1 : 0));
    chk({tag, " beats_left"}, 128'(sb.size()), 128'(0));
    chk({tag, " valid_cycles"}, 128'(valid_cycles), 128'(exp_valid));

    @(posedge clk); #1;
    START = 1'b0; MEM_READY = 1'b1; ABORT = 1'b0;
    @(negedge clk);
    chk({tag, " idle_busy"}, 128'(BUSY), 128'(1'b0));
    chk({tag, " idle_done"}, 128'(DONE), 128'(1'b0));
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({ACCESS_VALID, REG_NUM, ADDR, IS_LOAD, WB_EN, WB_REG,
                 WB_VALUE, PC_LOADED, ABORTED, BUSY, DONE});
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; START = 1'b0; IR = 32'h0; BASE = 32'h0;
    MEM_READY = 1'b1; ABORT = 1'b0;

    //       id  IR            BASE          stl abt pk start         wb  wbv           pc ab done
    add_vec(1, 32'hE8B1_00F0, 32'h0000_1000, 0, -1, 1, 32'h0000_1000, 1, 32'h0000_1010, 0, 0, 6);
    add_vec(2, 32'hE92D_4003, 32'h0000_2000, 0, -1, 0, 32'h0000_1FF4, 1, 32'h0000_1FF4, 0, 0, 5);
    add_vec(3, 32'hE9B2_8004, 32'h0000_4000, 2, -1, 0, 32'h0000_4004, 0, 32'h0,        1, 0, 5);
    add_vec(4, 32'hE833_0007, 32'h0000_5000, 0,  1, 0, 32'h0000_4FF8, 0, 32'h0,        0, 1, 3);
`ifdef LDM_STM_EMPTY_LIST_R15_EN
    add_vec(5, 32'hE8A4_0000, 32'h0000_3000, 0, -1, 0, 32'h0000_3000, 1, 32'h0000_3040, 0, 0, 3);
`else
    add_vec(5, 32'hE8A4_0000, 32'h0000_3000, 0, -1, 0, 32'h0000_3000, 0, 32'h0,        0, 0, 1);
`endif
    add_vec(6, 32'hE915_8001, 32'h0000_0100, 0, -1, 0, 32'h0000_00F8, 0, 32'h0,        1, 0, 3);
    add_vec(7, 32'hE8A6_0001, 32'h0000_1003, 0, -1, 0, 32'h0000_1000, 1, 32'h0000_1007, 0, 0, 3);
    add_vec(8, 32'hE927_0003, 32'h0000_0004, 0, -1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 4);
    add_vec(9, 32'hE8B0_FFFF, 32'h0000_0000, 0, -1, 1, 32'h0000_0000, 0, 32'h0,        1, 0, 17);

    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 128'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 128'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Reset during the second beat of a four-register LDM.
    @(posedge clk); #1;
    START = 1'b1; IR = 32'hE8B1_000F; BASE = 32'h0000_8000; MEM_READY = 1'b1;
    @(posedge clk); #1;
    START = 1'b0; IR = 32'h0; BASE = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_valid", 128'(ACCESS_VALID), 128'(1'b1));
    chk("mid_reg", 128'(REG_NUM), 128'(4'd1));
    chk("mid_addr", 128'(ADDR), 128'(32'h0000_8004));
    #1 rst = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 128'h0);
    @(negedge clk);
    chk("held_reset_outputs", all_outs(), 128'h0);
    rst = 1'b1;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
